// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state encoding, the operand widths and the iteration count.
package alu_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int DIV_STEPS  = 8;
    localparam int CNT_W      = $clog2(DIV_STEPS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// compare against the divisor and conditionally subtract.
module div_step
    import alu_pkg::*;
(
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0]   shifted;
    logic [DIVISOR_W+1:0] shifted_wide;

    // The wide copy keeps the bit shifted out of the top so the compare
    // stays correct even when a zero divisor lets the remainder grow.
    assign shifted      = {rem_in[DIVISOR_W-1:0], bit_in};
    assign shifted_wide = {rem_in, bit_in};

    always_comb begin
        q_bit   = 1'b0;
        rem_out = shifted;
        if (shifted_wide >= {2'b00, divisor}) begin
            q_bit   = 1'b1;
            rem_out = shifted - {1'b0, divisor};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential 8/4 unsigned restoring divider, one quotient bit per clock.
// Define DIV_ZERO_FAST_EN to short-circuit a zero divisor straight to DONE.
module div_seq
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] A,
    input  logic [DIVISOR_W-1:0]  B,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] Q,
    output logic [DIVISOR_W-1:0]  R,
    output logic                  dz
);

    state_t                state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [DIVIDEND_W-1:0] a_reg;
    logic [DIVISOR_W-1:0]  b_reg;
    logic [DIVISOR_W:0]    rem_reg;
    logic [DIVIDEND_W-1:0] q_work_reg;
    logic [DIVIDEND_W-1:0] q_reg;
    logic [DIVISOR_W-1:0]  r_reg;
    logic                  dz_reg;

    logic [DIVISOR_W:0]    rem_next;
    logic                  q_bit;

    div_step u_step (
        .rem_in  (rem_reg),
        .bit_in  (a_reg[DIVIDEND_W-1]),
        .divisor (b_reg),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            rem_reg    <= '0;
            q_work_reg <= '0;
            q_reg      <= '0;
            r_reg      <= '0;
            dz_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg      <= A;
                        b_reg      <= B;
                        rem_reg    <= '0;
                        cnt_reg    <= '0;
                        q_work_reg <= '0;
`ifdef DIV_ZERO_FAST_EN
                        if (B == '0) begin
                            state_reg <= DONE;
                            q_reg     <= '1;
                            r_reg     <= '0;
                            dz_reg    <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                        end
`else
                        state_reg <= RUN;
`endif
                    end
                end
                RUN: begin
                    a_reg      <= {a_reg[DIVIDEND_W-2:0], 1'b0};
                    rem_reg    <= rem_next;
                    q_work_reg <= {q_work_reg[DIVIDEND_W-2:0], q_bit};
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    // Results are published on the last step so they are stable throughout DONE.
                    if (cnt_reg == CNT_W'(DIV_STEPS - 1)) begin
                        state_reg <= DONE;
                        q_reg     <= {q_work_reg[DIVIDEND_W-2:0], q_bit};
                        r_reg     <= rem_next[DIVISOR_W-1:0];
                        dz_reg    <= (b_reg == '0);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign Q    = q_reg;
    assign R    = r_reg;
    assign dz   = dz_reg;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: scoreboard of expected results,
// one task per scenario, one line printed per division.
module tb_div_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] Q;
    logic [3:0] R;
    logic       dz;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   failures   = 0;
    int   done_count = 0;

    div_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_count++;

    function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        if (b == 4'd0) begin
            e.q  = 8'hFF;
            e.dz = 1'b1;
`ifdef DIV_ZERO_FAST_EN
            e.r   = 4'h0;
            e.lat = 1;
`else
            e.r   = a[3:0];
            e.lat = 9;
`endif
        end else begin
            e.q   = a / {4'd0, b};
            e.r   = 4'(a % {4'd0, b});
            e.dz  = 1'b0;
            e.lat = 9;
        end
        return e;
    endfunction

    // Issue one division, scramble A/B after capture, optionally fire extra
    // starts while RUN, then wait (bounded) for done and check the result.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input bit noisy);
        exp_t e;
        int   n;
        sb.push_back(model(a, b));
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 8'($urandom);
        B = 4'($urandom);
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            if (noisy && n < 6) begin
                start = 1'b1;
                A = 8'd17;
                B = 4'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout a=%0d b=%0d waited=%0d required_latency=%0d", a, b, n, e.lat);
        end else begin
            checks++;
            if (Q !== e.q) begin
                failures++;
                $display("FAIL quotient a=%0d b=%0d got=%0d expected=%0d", a, b, Q, e.q);
            end
            checks++;
            if (R !== e.r) begin
                failures++;
                $display("FAIL remainder a=%0d b=%0d got=%0d expected=%0d", a, b, R, e.r);
            end
            checks++;
            if (dz !== e.dz) begin
                failures++;
                $display("FAIL dz_flag a=%0d b=%0d got=%0b expected=%0b", a, b, dz, e.dz);
            end
            checks++;
            if (n !== e.lat) begin
                failures++;
                $display("FAIL latency a=%0d b=%0d got=%0d expected=%0d", a, b, n, e.lat);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL busy_in_done a=%0d b=%0d got=%0b expected=0", a, b, busy);
            end
        end
        $display("op a=%0d b=%0d -> Q=%0d R=%0d dz=%0b latency=%0d", a, b, Q, R, dz, n);
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width got=%0b expected=0", done);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        A     = 8'd200;
        B     = 4'd7;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, Q, R, dz} !== 15'd0) begin
            failures++;
            $display("FAIL reset_state busy=%0b done=%0b Q=%0d R=%0d dz=%0b expected all zero",
                     busy, done, Q, R, dz);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy got=%0b expected=0", busy);
        end
    endtask

    task automatic test_nominal();
        run_op(8'd200, 4'd7,  1'b0);
        run_op(8'd255, 4'd15, 1'b0);
        run_op(8'd9,   4'd10, 1'b0);
        run_op(8'd0,   4'd1,  1'b0);
        run_op(8'd255, 4'd1,  1'b0);
        run_op(8'd7,   4'd7,  1'b0);
    endtask

    task automatic test_div_zero();
        run_op(8'h5C, 4'd0, 1'b0);
        run_op(8'hA3, 4'd0, 1'b0);
    endtask

    task automatic test_ignored_start();
        int d0;
        d0 = done_count;
        run_op(8'd200, 4'd7, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done_count - d0 !== 1) begin
            failures++;
            $display("FAIL ignored_start_pulses got=%0d expected=1", done_count - d0);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_start_queued busy got=%0b expected=0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_count;
        A = 8'd100;
        B = 4'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy, Q, R, dz} !== 14'd0) begin
            failures++;
            $display("FAIL reset_mid_state busy=%0b Q=%0d R=%0d dz=%0b expected all zero",
                     busy, Q, R, dz);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (done_count !== d0) begin
            failures++;
            $display("FAIL reset_mid_done_pulse got=%0d expected=%0d", done_count, d0);
        end
        run_op(8'd100, 4'd3, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_op(8'($urandom), 4'($urandom), 1'b0);
        end
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        @(posedge clk); #1;
        test_reset();
        test_nominal();
        test_div_zero();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
